regstat_ckpt: RTL and testbench

- Parametrised register status table for the issue stage. Tracks, per architectural register, whether a result is pending and which ROB tag will produce it.
- Successor to the single-issue status table:
  - configurable register count, tag width and commit width;
  - commit-to-issue bypass on operand lookup;
  - branch checkpoints, so a misprediction restores a snapshot instead of clearing the whole table.

---
 rtl/structs_pkg.sv | 13 +
 rtl/regstat_ckpt_if.sv | 41 ++++
 rtl/regstat_clear_mask.sv | 35 +++
 rtl/regstat_ckpt.sv | 139 +++++++++++++
 tb/tb_regstat_ckpt.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/structs_pkg.sv
// Shared types for the register status table: one status entry per architectural register.
package structs_pkg;

  // The tag field is sized for the widest supported ROB. Narrower ROBs zero-extend into it.
  localparam int MAX_TAG_W        = 8;
  localparam int DEFAULT_NUM_CKPT = 4;

  typedef struct packed {
    logic                 busy;
    logic [MAX_TAG_W-1:0] tag;
  } reg_stat_t;

endpackage

// File: rtl/regstat_ckpt_if.sv
// Issue/commit/checkpoint bus of the register status table.
// The master side is the issue stage. The slave side is the table.
interface regstat_ckpt_if #(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 4,
  parameter int COMMIT_W = 2,
  parameter int NUM_CKPT = 4
);
  localparam int REG_W  = $clog2(NUM_REGS);
  localparam int CKPT_W = $clog2(NUM_CKPT);

  logic                      issue_valid;
  logic [REG_W-1:0]          issue_dest;
  logic [TAG_W-1:0]          issue_rob;
  logic [REG_W-1:0]          rs1, rs2;
  logic [TAG_W-1:0]          q_j, q_k;
  logic                      rs1_busy, rs2_busy;
  logic [COMMIT_W-1:0]       commit_valid;
  logic [COMMIT_W*REG_W-1:0] commit_dest;
  logic [COMMIT_W*TAG_W-1:0] commit_rob;
  logic                      ckpt_take;
  logic [CKPT_W-1:0]         ckpt_id;
  logic                      ckpt_full;
  logic                      ckpt_release;
  logic                      restore_valid;
  logic [CKPT_W-1:0]         restore_id;

  modport master (
    output issue_valid, issue_dest, issue_rob, rs1, rs2,
           commit_valid, commit_dest, commit_rob,
           ckpt_take, ckpt_release, restore_valid, restore_id,
    input  q_j, q_k, rs1_busy, rs2_busy, ckpt_id, ckpt_full
  );

  modport slave (
    input  issue_valid, issue_dest, issue_rob, rs1, rs2,
           commit_valid, commit_dest, commit_rob,
           ckpt_take, ckpt_release, restore_valid, restore_id,
    output q_j, q_k, rs1_busy, rs2_busy, ckpt_id, ckpt_full
  );
endinterface

// File: rtl/regstat_clear_mask.sv
// Per-register clear vector from the commit ports. It is shared by the live table and the snapshots.
// An entry clears when any commit port names it with a matching tag and no issue write lands on it.
module regstat_clear_mask
  import structs_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  parameter  int TAG_W    = 4,
  parameter  int COMMIT_W = 2,
  localparam int REG_W    = $clog2(NUM_REGS)
) (
  input  reg_stat_t [NUM_REGS-1:0] tbl,
  input  logic [COMMIT_W-1:0]       commit_valid,
  input  logic [COMMIT_W*REG_W-1:0] commit_dest,
  input  logic [COMMIT_W*TAG_W-1:0] commit_rob,
  input  logic                      issue_we,
  input  logic [REG_W-1:0]          issue_dest,
  output logic [NUM_REGS-1:0]       clear
);

  always_comb begin
    // NOTE: every output gets a default first, so no latch can be inferred.
    clear = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int p = 0; p < COMMIT_W; p++) begin
        if (r != 0 && commit_valid[p] && tbl[r].busy &&
            commit_dest[p*REG_W +: REG_W] == REG_W'(r) &&
            tbl[r].tag == MAX_TAG_W'(commit_rob[p*TAG_W +: TAG_W]))
          clear[r] = 1'b1;
      end
      if (issue_we && issue_dest == REG_W'(r))
        clear[r] = 1'b0;
    end
  end

endmodule

// File: rtl/regstat_ckpt.sv
// Register status table with commit bypass and branch checkpoints.
// Defining REGSTAT_CKPT_EN enables the checkpoints. Without it, restore_valid acts as a flush.
module regstat_ckpt
  import structs_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  parameter  int TAG_W    = 4,
  parameter  int COMMIT_W = 2,
  parameter  int NUM_CKPT = DEFAULT_NUM_CKPT,
  localparam int REG_W    = $clog2(NUM_REGS),
  localparam int CKPT_W   = $clog2(NUM_CKPT)
) (
  input logic           clk,
  input logic           reset_n,
  input logic           stall,
  input logic           flush,
  regstat_ckpt_if.slave bus
);

  reg_stat_t [NUM_REGS-1:0] tbl_q, tbl_d, tbl_upd;
  logic      [NUM_REGS-1:0] live_clr;
  logic                     issue_we;

  assign issue_we = bus.issue_valid && !stall && !bus.restore_valid && (bus.issue_dest != '0);

  regstat_clear_mask #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .COMMIT_W(COMMIT_W)) u_live_mask (
    .tbl(tbl_q), .commit_valid(bus.commit_valid), .commit_dest(bus.commit_dest),
    .commit_rob(bus.commit_rob), .issue_we(issue_we), .issue_dest(bus.issue_dest),
    .clear(live_clr)
  );

  // Next table in the absence of a restore. Issue is applied last so that it wins over a commit.
  always_comb begin
    tbl_upd = tbl_q;
    for (int r = 0; r < NUM_REGS; r++)
      if (live_clr[r]) tbl_upd[r] = '0;
    if (issue_we)
      tbl_upd[bus.issue_dest] = '{busy: 1'b1, tag: MAX_TAG_W'(bus.issue_rob)};
  end

  // Operand lookup from the registered table. A commit landing this cycle makes the operand ready.
  always_comb begin
    bus.rs1_busy = 1'b0;
    bus.q_j      = '0;
    bus.rs2_busy = 1'b0;
    bus.q_k      = '0;
    if (bus.rs1 != '0) begin
      bus.rs1_busy = tbl_q[bus.rs1].busy && !live_clr[bus.rs1];
      bus.q_j      = tbl_q[bus.rs1].tag[TAG_W-1:0];
    end
    if (bus.rs2 != '0) begin
      bus.rs2_busy = tbl_q[bus.rs2].busy && !live_clr[bus.rs2];
      bus.q_k      = tbl_q[bus.rs2].tag[TAG_W-1:0];
    end
  end

`ifdef REGSTAT_CKPT_EN
  reg_stat_t [NUM_REGS-1:0] slot_q [NUM_CKPT];
  reg_stat_t [NUM_REGS-1:0] slot_d [NUM_CKPT];
  logic      [NUM_REGS-1:0] slot_clr [NUM_CKPT];
  logic [CKPT_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CKPT_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              take_acc, rel_acc;

  for (genvar s = 0; s < NUM_CKPT; s++) begin : g_slot
    regstat_clear_mask #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .COMMIT_W(COMMIT_W)) u_mask (
      .tbl(slot_q[s]), .commit_valid(bus.commit_valid), .commit_dest(bus.commit_dest),
      .commit_rob(bus.commit_rob), .issue_we(1'b0), .issue_dest('0), .clear(slot_clr[s])
    );
  end

  always_comb begin
    take_acc = bus.ckpt_take && !stall && !full_q && !bus.restore_valid;
    rel_acc  = bus.ckpt_release && (count_q != '0);
    // Snapshots see the same commit clears as the live table, so they never go stale.
    for (int s = 0; s < NUM_CKPT; s++) begin
      slot_d[s] = slot_q[s];
      for (int r = 0; r < NUM_REGS; r++)
        if (slot_clr[s][r]) slot_d[s][r] = '0;
    end
    head_d = head_q + CKPT_W'(rel_acc);
    tbl_d  = tbl_upd;
    if (bus.restore_valid) begin
      tbl_d   = slot_d[bus.restore_id];
      tail_d  = bus.restore_id;
      count_d = {1'b0, bus.restore_id - head_d};
    end else begin
      tail_d  = tail_q + CKPT_W'(take_acc);
      count_d = count_q + (CKPT_W+1)'(take_acc) - (CKPT_W+1)'(rel_acc);
      if (take_acc) slot_d[tail_q] = tbl_upd;
    end
    if (flush) begin
      tbl_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    full_d = (count_d == (CKPT_W+1)'(NUM_CKPT));
  end

  // NOTE: snapshot storage has no reset. head/tail/count alone decide which slots hold valid data.
  always_ff @(posedge clk) slot_q <= slot_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign bus.ckpt_id   = tail_q;
  assign bus.ckpt_full = full_q;
`else
  logic unused_ckpt;
  assign unused_ckpt = ^{bus.ckpt_take, bus.ckpt_release, bus.restore_id};

  always_comb begin
    tbl_d = tbl_upd;
    if (flush || bus.restore_valid) tbl_d = '0;
  end

  assign bus.ckpt_id   = '0;
  assign bus.ckpt_full = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tbl_q <= '0;
    else          tbl_q <= tbl_d;
  end

endmodule

// File: tb/tb_regstat_ckpt.sv
// Directed bench for regstat_ckpt. Its expectations follow whether REGSTAT_CKPT_EN is defined.
module tb_regstat_ckpt;
  localparam int NUM_REGS = 32;
  localparam int TAG_W    = 4;
  localparam int COMMIT_W = 2;
  localparam int NUM_CKPT = 4;
  localparam int REG_W    = $clog2(NUM_REGS);
  localparam int CKPT_W   = $clog2(NUM_CKPT);
`ifdef REGSTAT_CKPT_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  logic reset_n, stall, flush;
  int   n_checks = 0;
  int   n_errors = 0;

  regstat_ckpt_if #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .COMMIT_W(COMMIT_W),
                    .NUM_CKPT(NUM_CKPT)) bus ();

  regstat_ckpt #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .COMMIT_W(COMMIT_W),
                 .NUM_CKPT(NUM_CKPT)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 1'b0;
    flush = 1'b0;
    bus.issue_valid   = 1'b0;
    bus.issue_dest    = '0;
    bus.issue_rob     = '0;
    bus.commit_valid  = '0;
    bus.commit_dest   = '0;
    bus.commit_rob    = '0;
    bus.ckpt_take     = 1'b0;
    bus.ckpt_release  = 1'b0;
    bus.restore_valid = 1'b0;
    bus.restore_id    = '0;
  endtask

  // Apply the currently driven inputs at the next edge, then return to idle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input int d, input int t);
    bus.issue_valid = 1'b1;
    bus.issue_dest  = REG_W'(d);
    bus.issue_rob   = TAG_W'(t);
  endtask

  task automatic commit(input int p, input int d, input int t);
    bus.commit_valid[p]              = 1'b1;
    bus.commit_dest[p*REG_W +: REG_W] = REG_W'(d);
    bus.commit_rob[p*TAG_W +: TAG_W]  = TAG_W'(t);
  endtask

  // Looks up register r on both read ports. The tag is compared only when chk_q is set.
  task automatic expect_reg(input string tag, input int r, input int busy, input int q,
                            input bit chk_q);
    bus.rs1 = REG_W'(r);
    bus.rs2 = REG_W'(r);
    #1;
    check({tag, ".rs1_busy"}, 32'(bus.rs1_busy), busy);
    check({tag, ".rs2_busy"}, 32'(bus.rs2_busy), busy);
    if (chk_q) begin
      check({tag, ".q_j"}, 32'(bus.q_j), q);
      check({tag, ".q_k"}, 32'(bus.q_k), q);
    end
  endtask

  task automatic expect_ckpt(input string tag, input int id, input int full);
    check({tag, ".ckpt_id"},   32'(bus.ckpt_id),   id);
    check({tag, ".ckpt_full"}, 32'(bus.ckpt_full), full);
  endtask

  initial begin
    reset_n = 1'b1;
    idle();
    bus.rs1 = '0;
    bus.rs2 = '0;
    #1 reset_n = 1'b0;
    #1;
    expect_reg("reset", 0, 0, 0, 1'b1);
    expect_ckpt("reset", 0, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Basic issue, commit bypass and register 0
    issue(5, 3); cyc();
    expect_reg("iss_x5", 5, 1, 3, 1'b1);
    commit(0, 5, 3);
    expect_reg("byp_x5", 5, 0, 0, 1'b0);
    cyc();
    expect_reg("clr_x5", 5, 0, 0, 1'b1);
    issue(0, 6); cyc();
    expect_reg("x0", 0, 0, 0, 1'b1);

    // Tag mismatch, issue beats commit, stall blocks issue but not commit
    issue(5, 3); cyc();
    issue(5, 7); cyc();
    commit(0, 5, 3); cyc();
    expect_reg("stale_commit", 5, 1, 7, 1'b1);
    commit(0, 5, 7); commit(1, 5, 7); issue(5, 9); cyc();
    expect_reg("issue_wins", 5, 1, 9, 1'b1);
    stall = 1'b1; issue(6, 2); commit(0, 5, 2); commit(1, 5, 9);
    expect_reg("stall_byp", 5, 0, 0, 1'b0);
    cyc();
    expect_reg("port1_clr", 5, 0, 0, 1'b1);
    expect_reg("stall_iss", 6, 0, 0, 1'b1);

    // flush
    issue(7, 1); cyc();
    flush = 1'b1; cyc();
    expect_reg("flush", 7, 0, 0, 1'b1);

    // Snapshot cleared by a commit, then restored
    issue(2, 1); cyc();
    bus.ckpt_take = 1'b1; #1;
    expect_ckpt("take0_pre", 0, 0);
    cyc();
    expect_ckpt("take0_post", CK, 0);
    issue(2, 4); cyc();
    issue(8, 5); cyc();
    commit(0, 2, 1); cyc();
    expect_reg("live_x2", 2, 1, 4, 1'b1);
    bus.restore_valid = 1'b1; bus.restore_id = '0; issue(12, 3); cyc();
    expect_reg("rst0_x2", 2, 0, 0, 1'b1);
    expect_reg("rst0_x8", 8, 0, 0, 1'b1);
    expect_reg("rst0_x12", 12, 0, 0, 1'b1);
    expect_ckpt("rst0", 0, 0);

    // Snapshots hold busy bits; a restore applies same-cycle commit clears
    issue(3, 2); cyc();
    bus.ckpt_take = 1'b1; cyc();
    issue(3, 6); bus.ckpt_take = 1'b1; cyc();
    expect_ckpt("two_takes", 2 * CK, 0);
    issue(9, 11); cyc();
    bus.restore_valid = 1'b1; bus.restore_id = CKPT_W'(1); cyc();
    expect_reg("rst1_x3", 3, CK, 6 * CK, 1'b1);
    expect_reg("rst1_x9", 9, 0, 0, 1'b1);
    expect_ckpt("rst1", CK, 0);
    bus.restore_valid = 1'b1; bus.restore_id = '0; commit(1, 3, 2); cyc();
    expect_reg("rst0c_x3", 3, 0, 0, 1'b1);
    expect_ckpt("rst0c", 0, 0);

    // Fill, overflow, release, take+release
    flush = 1'b1; cyc();
    for (int i = 0; i < 3; i++) begin
      bus.ckpt_take = 1'b1; cyc();
    end
    expect_ckpt("three", 3 * CK, 0);
    bus.ckpt_take = 1'b1; cyc();
    expect_ckpt("four_full", 0, CK);
    bus.ckpt_take = 1'b1; cyc();
    expect_ckpt("fifth_ignored", 0, CK);
    bus.ckpt_release = 1'b1; cyc();
    expect_ckpt("release", 0, 0);
    bus.ckpt_take = 1'b1; bus.ckpt_release = 1'b1; cyc();
    expect_ckpt("take_rel", CK, 0);
    bus.ckpt_take = 1'b1; cyc();
    expect_ckpt("refill", 2 * CK, CK);

    // Asynchronous reset with a busy table and three live checkpoints
    bus.ckpt_release = 1'b1; cyc();
    issue(10, 12); cyc();
    expect_reg("pre_rst", 10, 1, 12, 1'b1);
    reset_n = 1'b0; #1;
    expect_reg("async_rst", 10, 0, 0, 1'b1);
    expect_ckpt("async_rst", 0, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ckpt_take = 1'b1; cyc();
    end
    expect_ckpt("post_rst3", 3 * CK, 0);
    bus.ckpt_take = 1'b1; cyc();
    expect_ckpt("post_rst4", 0, CK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
